btn_event_scheduler: RTL

- Shared front end for all board push-buttons.
- Generates one divided sample strobe, debounces every raw button against it, and converts each press into a single pending event.
- A round-robin scheduler delivers pending events one at a time over a valid/ready handshake to the downstream consumer (menu/FSM logic).
- Replaces per-button divider and single-pulse instances with one sequenced resource.

---
 rtl/btn_sched_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 54 +++++
 rtl/btn_event_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/btn_sched_pkg.sv
// Shared types and helpers for the push-button event scheduler.
package btn_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

    // 100 MHz clock divided down to a 2.5 ms sample strobe.
    localparam int TICK_DIV_DEFAULT = 250000;

    // Width of an index or counter covering n values; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, sample history, debounced
// level and a one-cycle pulse marking each rising edge of that level.
module btn_debounce_ch #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic sample_tick,
    output logic level,
    output logic rise
);

    logic [1:0]                sync;
    logic [STABLE_SAMPLES-1:0] hist;
    logic [STABLE_SAMPLES-1:0] hist_next;

    // The raw pin is asynchronous, so it passes through two flops every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    if (STABLE_SAMPLES == 1) begin : g_hist_one
        assign hist_next = sync[1];
    end else begin : g_hist_many
        assign hist_next = {hist[STABLE_SAMPLES-2:0], sync[1]};
    end

    // On each strobe shift in a sample; the level only moves once the whole
    // history agrees, and the rise pulse coincides with the first high cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sample_tick) begin
                hist <= hist_next;
                if (&hist_next) begin
                    level <= 1'b1;
                    rise  <= ~level;
                end else if (~|hist_next) begin
                    level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/btn_event_scheduler.sv
// Shared push-button front end: one sample strobe, NUM_BTN debounced
// channels, a pending-event vector and a round-robin valid/ready scheduler.
// Optional per-channel auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_event_scheduler import btn_sched_pkg::*; #(
    parameter int NUM_BTN        = 5,
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
`ifdef BTN_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_PERIOD  = 40,
`endif
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_BTN-1:0]        btn,
    output logic                      sample_tick,
    output logic [NUM_BTN-1:0]        btn_level,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [idw(NUM_BTN)-1:0]   evt_id,
    output logic                      evt_drop
);

    localparam int IDW = idw(NUM_BTN);
    localparam int TCW = idw(TICK_DIV);

    logic [TCW-1:0]     tick_cnt;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant_mask;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_en;
    logic               found;
    sched_state_t       state;
    sched_state_t       state_d;

    // Index offset+1 positions past base, wrapped into 0..NUM_BTN-1.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int idx;
        idx = int'(base) + 1 + offset;
        if (idx >= NUM_BTN) idx = idx - NUM_BTN;
        return IDW'(idx);
    endfunction

    assign sample_tick = (tick_cnt == TCW'(TICK_DIV - 1));

    // Free-running divider that produces the shared sample strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TCW'(1);
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .btn_raw     (btn[i]),
            .sample_tick (sample_tick),
            .level       (btn_level[i]),
            .rise        (rise[i])
        );
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RCW = idw(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [NUM_BTN-1:0] rep_req;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_rep
        logic [RCW-1:0] rcnt;
        logic [RCW-1:0] rnext;
        logic           rep_q;

        assign rnext      = rcnt + RCW'(1);
        assign rep_req[i] = rep_q;

        // Count strobes while held; fire at the delay, then every period after.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rcnt  <= '0;
                rep_q <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (!btn_level[i]) begin
                    rcnt <= '0;
                end else if (sample_tick) begin
                    rep_q <= (rnext == RCW'(REPEAT_DELAY)) ||
                             (rnext == RCW'(REPEAT_DELAY + REPEAT_PERIOD));
                    rcnt  <= (rnext == RCW'(REPEAT_DELAY + REPEAT_PERIOD)) ?
                             RCW'(REPEAT_DELAY) : rnext;
                end
            end
        end
    end

    assign req = rise | rep_req;
`else
    assign req = rise;
`endif

    // Round-robin search for the first pending channel after the last grant.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            if (!found && pending[rr_index(last_grant, k)]) begin
                found     = 1'b1;
                grant_idx = rr_index(last_grant, k);
            end
        end
    end

    // Next-state logic: grant only from IDLE, so IDLE always lasts a cycle.
    always_comb begin
        state_d  = state;
        grant_en = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_en = 1'b1;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot of the channel being granted this cycle, used to clear pending.
    always_comb begin
        grant_mask = '0;
        if (grant_en) grant_mask[grant_idx] = 1'b1;
    end

    // Scheduler state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    assign evt_valid = (state == OFFER);

    // Pending vector, offered id and grant history; a new request beats a
    // same-cycle grant, and a request onto a still-pending bit is a merge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            evt_id     <= '0;
            evt_drop   <= 1'b0;
            last_grant <= IDW'(NUM_BTN - 1);
        end else begin
            pending  <= (pending & ~grant_mask) | req;
            evt_drop <= |(req & pending & ~grant_mask);
            if (grant_en) evt_id <= grant_idx;
            if ((state == OFFER) && evt_ready) last_grant <= evt_id;
        end
    end

endmodule
